offset_pipe: RTL and testbench
==============================

Name: offset_pipe

Overview:
- Parametrised successor of the single-stage offset register.
- Takes an IN_W-bit immediate and extends it to DATA_W bits in one of four modes. Also adds the result to a base value (PC or register) to form a target.
- Carries result and target through a STAGES-deep pipeline with valid, stall (en) and flush control.
- Sits between instruction decode and the execute/branch unit; feeds the B-operand mux and the branch-target path.

Parameters:
- IN_W, 8, immediate width; legal range 1 .. DATA_W-1.
- DATA_W, 16, datapath width.
- STAGES, 2, pipeline depth (latency in enabled cycles); legal minimum 1.
- SHIFT, 1, left-shift amount for mode 2; legal range 0 .. DATA_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance pipeline; low = stall, all stages hold.
- flush  input  1  kill all in-flight entries.
- in_valid  input  1  imm/mode/base are a valid entry this cycle.
- imm  input  IN_W  raw immediate.
- mode  input  2  extension mode (see Behaviour).
- base  input  DATA_W  base operand for target.
- out_valid  output  1  dataout/target valid.
- dataout  output  DATA_W  extended offset, final stage.
- target  output  DATA_W  base + extended offset, final stage.

Behaviour:
- Extension, computed combinationally from imm and mode before stage 1:
  - 2'b00: sign-extend imm to DATA_W.
  - 2'b01: zero-extend.
  - 2'b10: sign-extend, then shift left by SHIFT. Bits shifted past DATA_W are discarded; zeros fill the LSBs.
  - 2'b11: upper load, i.e. imm placed in bits [DATA_W-1 : DATA_W-IN_W], lower bits zero.
- Target = base + ext, modulo 2^DATA_W. No carry or overflow output; wrap-around is silent.
- Target is computed combinationally before stage 1 and registered with ext in stage 1.
- Pipeline: stages 1..STAGES each hold {valid, ext, target}. Outputs are driven directly from stage STAGES registers; no combinational path from inputs to outputs.
- Priority per posedge: rst > flush > en.
  - rst=1: all valid bits = 0, all data registers = 0. Outputs are therefore out_valid=0, dataout=0, target=0.
  - flush=1 (rst=0): all valid bits cleared, data registers zeroed. The input presented in the same cycle is dropped, regardless of en.
  - en=1: stage1 <= {in_valid, ext, target}; stage k <= stage k-1 for k=2..STAGES.
  - en=0: every stage holds, including valid. in_valid is ignored and the input is lost; upstream must hold it.
- Entries with in_valid=0 still shift through as bubbles. Their data fields are captured as-is and are don't-care when valid=0.
- Latency: an entry accepted at edge N (en=1) appears on the outputs after edge N+STAGES-1, provided en=1 on each intervening edge. Each stall cycle adds one.
- Throughput: one entry per enabled cycle.
- Reset asserted mid-stream discards all in-flight entries. The first entry after rst deasserts follows normal latency.
- No $display or other simulation-only constructs in synthesizable RTL.

Test Plan:
- Mode sweep (IN_W=8, DATA_W=16, SHIFT=1), imm=8'hF0, base=16'h0100, en=1. Required dataout 2 edges later:
  - mode 00 -> 16'hFFF0, target 16'h00F0.
  - mode 01 -> 16'h00F0, target 16'h01F0.
  - mode 10 -> 16'hFFE0, target 16'h00E0.
  - mode 11 -> 16'hF000, target 16'hF100.
- Wrap: mode 01, imm=8'h01, base=16'hFFFF -> target 16'h0000, out_valid=1.
- Stall: accept imm=8'h7F mode 00, then en=0 for 3 cycles -> out_valid stays 0 until 2 enabled edges have passed. The value 16'h007F appears exactly once, and the outputs hold during the stall.
- Back-to-back stream: imm 8'h01, 8'h02, 8'h03 on consecutive enabled cycles with in_valid=1 -> dataout 16'h0001, 16'h0002, 16'h0003 on consecutive cycles with out_valid=1, starting at latency 2.
- Flush: two valid entries in flight, assert flush with en=1 and in_valid=1 -> next cycle out_valid=0, dataout=0, target=0. The flushed-cycle input never appears.
- Reset priority: rst=1 with flush=1 and en=1 mid-stream -> all outputs 0 after the edge. After rst deasserts, a new entry appears at normal latency.

Source files
------------

// File: rtl/offset_pipe.sv
// Immediate extender with base-relative target, carried through a STAGES-deep
// pipeline with valid, stall (en) and flush control.
module offset_pipe #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned SHIFT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   imm,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] base,
  output logic              out_valid,
  output logic [DATA_W-1:0] dataout,
  output logic [DATA_W-1:0] target
);

  localparam int unsigned PAD_W = DATA_W - IN_W;

  logic [DATA_W-1:0] sext_c;
  logic [DATA_W-1:0] ext_c;
  logic [DATA_W-1:0] target_c;

  logic              valid_q  [STAGES];
  logic [DATA_W-1:0] ext_q    [STAGES];
  logic [DATA_W-1:0] target_q [STAGES];

  // Extension and target formation ahead of stage 1
  always_comb begin
    sext_c = {{PAD_W{imm[IN_W-1]}}, imm};
    ext_c  = sext_c;
    case (mode)
      2'b00:   ext_c = sext_c;
      2'b01:   ext_c = {{PAD_W{1'b0}}, imm};
      2'b10:   ext_c = DATA_W'(sext_c << SHIFT);
      default: ext_c = {imm, {PAD_W{1'b0}}};
    endcase
    target_c = DATA_W'(base + ext_c);
  end

  // Stage registers; rst and flush both zero every stage, en advances all
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k]  <= 1'b0;
        ext_q[k]    <= '0;
        target_q[k] <= '0;
      end
    end else if (en) begin
      valid_q[0]  <= in_valid;
      ext_q[0]    <= ext_c;
      target_q[0] <= target_c;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k]  <= valid_q[k-1];
        ext_q[k]    <= ext_q[k-1];
        target_q[k] <= target_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign dataout   = ext_q[STAGES-1];
  assign target    = target_q[STAGES-1];

endmodule

// File: tb/tb_offset_pipe.sv
// Self-checking bench for offset_pipe: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a queue-based model.
module tb_offset_pipe;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned STAGES = 2;
  localparam int unsigned SHIFT  = 1;

  logic              clk = 1'b0;
  logic              rst, en, flush, in_valid;
  logic [IN_W-1:0]   imm;
  logic [1:0]        mode;
  logic [DATA_W-1:0] base;
  logic              out_valid;
  logic [DATA_W-1:0] dataout, target;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] t;
  } ent_t;

  typedef struct {
    logic [IN_W-1:0]   imm;
    logic [1:0]        mode;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] exp_d;
    logic [DATA_W-1:0] exp_t;
  } vec_t;

  ent_t q[$];

  offset_pipe #(.IN_W(IN_W), .DATA_W(DATA_W), .STAGES(STAGES), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .imm(imm), .mode(mode), .base(base),
    .out_valid(out_valid), .dataout(dataout), .target(target)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ext_ref(logic [IN_W-1:0] i, logic [1:0] m);
    int s;
    s = (int'(i) >= (1 << (IN_W - 1))) ? int'(i) - (1 << IN_W) : int'(i);
    case (m)
      2'd0:    return DATA_W'(s);
      2'd1:    return DATA_W'(int'(i));
      2'd2:    return DATA_W'(s * (1 << SHIFT));
      default: return DATA_W'(int'(i) * (1 << (DATA_W - IN_W)));
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_out(string name, logic v, logic [DATA_W-1:0] d, logic [DATA_W-1:0] t);
    check({name, "_valid"}, 32'(out_valid), 32'(v));
    check({name, "_data"}, 32'(dataout), 32'(d));
    check({name, "_target"}, 32'(target), 32'(t));
  endtask

  // One clock edge; the model advances from the inputs seen at that edge
  task automatic tick();
    ent_t e, z;
    logic r, f, n;
    r = rst; f = flush; n = en;
    e.v = in_valid;
    e.d = ext_ref(imm, mode);
    e.t = DATA_W'(int'(base) + int'(e.d));
    z.v = 1'b0; z.d = '0; z.t = '0;
    @(posedge clk);
    #1;
    if (r || f) begin
      q.delete();
      for (int i = 0; i < STAGES; i++) q.push_back(z);
    end else if (n) begin
      q.push_front(e);
      void'(q.pop_back());
    end
    expect_out("model", q[STAGES-1].v, q[STAGES-1].d, q[STAGES-1].t);
  endtask

  task automatic drive(logic v, logic [IN_W-1:0] i, logic [1:0] m, logic [DATA_W-1:0] b);
    in_valid = v; imm = i; mode = m; base = b;
  endtask

  vec_t vecs[5];

  initial begin
    ent_t z;
    z.v = 1'b0; z.d = '0; z.t = '0;
    for (int i = 0; i < STAGES; i++) q.push_back(z);

    vecs[0] = '{8'hF0, 2'b00, 16'h0100, 16'hFFF0, 16'h00F0};
    vecs[1] = '{8'hF0, 2'b01, 16'h0100, 16'h00F0, 16'h01F0};
    vecs[2] = '{8'hF0, 2'b10, 16'h0100, 16'hFFE0, 16'h00E0};
    vecs[3] = '{8'hF0, 2'b11, 16'h0100, 16'hF000, 16'hF100};
    vecs[4] = '{8'h01, 2'b01, 16'hFFFF, 16'h0001, 16'h0000};

    // Reset state
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    drive(1'b1, 8'hAA, 2'b01, 16'h1234);
    tick(); tick();
    expect_out("reset", 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    drive(1'b0, 8'h00, 2'b00, 16'h0000);
    tick(); tick();

    // Mode sweep and wrap-around
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].imm, vecs[k].mode, vecs[k].base);
      tick();
      drive(1'b0, 8'h00, 2'b00, 16'h0000);
      tick();
      expect_out($sformatf("vec%0d", k), 1'b1, vecs[k].exp_d, vecs[k].exp_t);
    end
    tick();

    // Stall: accept, hold three cycles, then release
    drive(1'b1, 8'h7F, 2'b00, 16'h0000);
    tick();
    en = 1'b0;
    drive(1'b1, 8'h55, 2'b01, 16'h0000);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_wait_valid", 32'(out_valid), 32'd0);
    end
    en = 1'b1;
    drive(1'b0, 8'h00, 2'b00, 16'h0000);
    tick();
    expect_out("stall_out", 1'b1, 16'h007F, 16'h007F);
    en = 1'b0;
    tick(); tick();
    expect_out("stall_hold", 1'b1, 16'h007F, 16'h007F);
    en = 1'b1;
    tick();
    check("stall_once", 32'(out_valid), 32'd0);

    // Back-to-back stream
    drive(1'b1, 8'h01, 2'b01, 16'h0000); tick();
    check("b2b_lat", 32'(out_valid), 32'd0);
    drive(1'b1, 8'h02, 2'b01, 16'h0000); tick();
    expect_out("b2b_1", 1'b1, 16'h0001, 16'h0001);
    drive(1'b1, 8'h03, 2'b01, 16'h0000); tick();
    expect_out("b2b_2", 1'b1, 16'h0002, 16'h0002);
    drive(1'b0, 8'h00, 2'b00, 16'h0000); tick();
    expect_out("b2b_3", 1'b1, 16'h0003, 16'h0003);

    // Flush with two entries in flight; flushed-cycle input is dropped
    drive(1'b1, 8'h11, 2'b01, 16'h0000); tick();
    drive(1'b1, 8'h22, 2'b01, 16'h0000); tick();
    flush = 1'b1;
    drive(1'b1, 8'h33, 2'b01, 16'h0000); tick();
    expect_out("flush", 1'b0, 16'h0000, 16'h0000);
    flush = 1'b0;
    drive(1'b0, 8'h00, 2'b00, 16'h0000);
    tick(); check("flush_drop1", 32'(out_valid), 32'd0);
    tick(); check("flush_drop2", 32'(out_valid), 32'd0);

    // Reset wins over flush and en mid-stream
    drive(1'b1, 8'h21, 2'b01, 16'h0000); tick();
    drive(1'b1, 8'h42, 2'b01, 16'h0000); tick();
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 8'h63, 2'b01, 16'h0000); tick();
    expect_out("rst_prio", 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0; flush = 1'b0;
    drive(1'b1, 8'h44, 2'b01, 16'h0010); tick();
    check("rst_lat", 32'(out_valid), 32'd0);
    drive(1'b0, 8'h00, 2'b00, 16'h0000); tick();
    expect_out("rst_after", 1'b1, 16'h0044, 16'h0054);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 4);
      en    = ($urandom_range(0, 99) < 75);
      drive(1'($urandom), IN_W'($urandom), 2'($urandom), DATA_W'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
